// File: rtl/alu_op_sequencer.sv
// Fetch/execute control sequencer for register-register ALU instructions; every output is registered.
// Optional build macro ALU_SEQ_R0_GUARD_EN: a destination of R0 is rejected through the ERR path.
module alu_op_sequencer #(
  parameter int NREG     = 16,
  parameter int MEM_WAIT = 0
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            start,
  input  logic [31:0]     bus,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            PCout,
  output logic            IncPC,
  output logic            MARin,
  output logic            Zin,
  output logic            Zlo_out,
  output logic            Zhi_out,
  output logic            PCin,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            LOin,
  output logic            HIin,
  output logic [NREG-1:0] rout,
  output logic [NREG-1:0] rin,
  output logic [4:0]      opcode
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2,
    S_B3, S_B4, S_B5,
    S_U3, S_U4,
    S_M3, S_M4, S_M5, S_M6,
    S_ERR
  } state_t;

  typedef struct packed {
    logic busy, done, err, pcout, incpc, marin, zin, zlo_out, zhi_out;
    logic pcin, read, mdrin, mdrout, irin, yin, loin, hiin;
  } strb_t;

  localparam logic [4:0]      NREG_L = 5'(NREG);
  localparam logic [3:0]      WAIT_L = 4'(MEM_WAIT);
  localparam logic [NREG-1:0] ONE    = NREG'(1);

  state_t          state_q, state_d, exec_state;
  logic [3:0]      wait_q, wait_d;
  logic [16:0]     ir_q, ir_d;
  strb_t           strb_q, strb_d;
  logic [NREG-1:0] rout_q, rout_d, rin_q, rin_d;
  logic [4:0]      opcode_q, opcode_d;
  logic            ra_bad, rb_bad, rc_bad;
  logic            bus_unused;

  // The low instruction bits carry no field this sequencer decodes.
  assign bus_unused = ^bus[14:0];

  // Classify the instruction on the bus while in T2; two-result ops do not name a destination.
  always_comb begin
    ra_bad = ({1'b0, bus[26:23]} >= NREG_L);
    rb_bad = ({1'b0, bus[22:19]} >= NREG_L);
    rc_bad = ({1'b0, bus[18:15]} >= NREG_L);
`ifdef ALU_SEQ_R0_GUARD_EN
    ra_bad = ra_bad | (bus[26:23] == 4'd0);
`endif
    exec_state = S_ERR;
    if (bus[31:27] <= 5'd14) begin
      if (!(ra_bad || rb_bad || rc_bad)) exec_state = S_B3;
    end else if (bus[31:27] <= 5'd16) begin
      if (!(rb_bad || rc_bad)) exec_state = S_M3;
    end else if (bus[31:27] <= 5'd18) begin
      if (!(ra_bad || rb_bad)) exec_state = S_U3;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wait_d  = '0;
      end
      S_T1: begin
        if (wait_q == WAIT_L) state_d = S_T2;
        else                  wait_d  = wait_q + 4'd1;
      end
      S_T2: begin
        ir_d    = bus[31:15];
        state_d = exec_state;
      end
      S_B3: state_d = S_B4;
      S_B4: state_d = S_B5;
      S_U3: state_d = S_U4;
      S_M3: state_d = S_M4;
      S_M4: state_d = S_M5;
      S_M5: state_d = S_M6;
      S_B5, S_U4, S_M6, S_ERR: state_d = start ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered so they appear registered in that state.
  always_comb begin
    strb_d   = '0;
    rout_d   = '0;
    rin_d    = '0;
    opcode_d = '0;
    strb_d.busy = (state_d != S_IDLE);
    case (state_d)
      S_T0: begin
        strb_d.pcout = 1'b1;
        strb_d.incpc = 1'b1;
        strb_d.marin = 1'b1;
        strb_d.zin   = 1'b1;
      end
      S_T1: begin
        strb_d.read  = 1'b1;
        strb_d.mdrin = 1'b1;
        if (state_q == S_T0) begin
          strb_d.zlo_out = 1'b1;
          strb_d.pcin    = 1'b1;
        end
      end
      S_T2: begin
        strb_d.mdrout = 1'b1;
        strb_d.irin   = 1'b1;
      end
      S_B3, S_M3: begin
        rout_d     = ONE << ir_d[7:4];
        strb_d.yin = 1'b1;
        opcode_d   = ir_d[16:12];
      end
      S_U3: begin
        rout_d     = ONE << ir_d[7:4];
        strb_d.zin = 1'b1;
        opcode_d   = ir_d[16:12];
      end
      S_B4, S_M4: begin
        rout_d     = ONE << ir_d[3:0];
        strb_d.zin = 1'b1;
        opcode_d   = ir_d[16:12];
      end
      S_B5, S_U4: begin
        strb_d.zlo_out = 1'b1;
        rin_d          = ONE << ir_d[11:8];
        strb_d.done    = 1'b1;
        opcode_d       = ir_d[16:12];
      end
      S_M5: begin
        strb_d.zlo_out = 1'b1;
        strb_d.loin    = 1'b1;
        opcode_d       = ir_d[16:12];
      end
      S_M6: begin
        strb_d.zhi_out = 1'b1;
        strb_d.hiin    = 1'b1;
        strb_d.done    = 1'b1;
        opcode_d       = ir_d[16:12];
      end
      S_ERR: begin
        strb_d.done = 1'b1;
        strb_d.err  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      ir_q     <= '0;
      strb_q   <= '0;
      rout_q   <= '0;
      rin_q    <= '0;
      opcode_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      ir_q     <= ir_d;
      strb_q   <= strb_d;
      rout_q   <= rout_d;
      rin_q    <= rin_d;
      opcode_q <= opcode_d;
    end
  end

  assign busy    = strb_q.busy;
  assign done    = strb_q.done;
  assign err     = strb_q.err;
  assign PCout   = strb_q.pcout;
  assign IncPC   = strb_q.incpc;
  assign MARin   = strb_q.marin;
  assign Zin     = strb_q.zin;
  assign Zlo_out = strb_q.zlo_out;
  assign Zhi_out = strb_q.zhi_out;
  assign PCin    = strb_q.pcin;
  assign Read    = strb_q.read;
  assign MDRin   = strb_q.mdrin;
  assign MDRout  = strb_q.mdrout;
  assign IRin    = strb_q.irin;
  assign Yin     = strb_q.yin;
  assign LOin    = strb_q.loin;
  assign HIin    = strb_q.hiin;
  assign rout    = rout_q;
  assign rin     = rin_q;
  assign opcode  = opcode_q;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Hardwired control sequencer for register-register ALU instructions on the 32-bit bus datapath. It replaces hand-driven per-instruction control sequences with one parametrised FSM covering fetch (T0-T2) and three execute shapes: binary, unary (NEG/NOT) and two-result (MUL/DIV). It sits beside the DataPath, snoops the bus during IR load, and drives the datapath enable and select strobes.

## Interface
Parameters:
- NREG, 16, number of general registers; width of `rout`/`rin`; legal values 2..16
- MEM_WAIT, 0, extra cycles T1 is held for memory read (0..15)

Ports:
- clock  in  1  system clock, rising edge
- clear  in  1  reset; one clock, asynchronous, active-high
- start  in  1  request one instruction; sampled only in IDLE or in the done cycle
- bus  in  32  BusMuxOut; captured as the instruction at the edge leaving T2
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse in the final state of an instruction
- err  out  1  one-cycle pulse, coincident with done, on an illegal instruction
- PCout, IncPC, MARin, Zin, Zlo_out, Zhi_out, PCin, Read, MDRin, MDRout, IRin, Yin, LOin, HIin  out  1 each  datapath strobes
- rout  out  NREG  one-hot register-out select (bit i = Ri_out)
- rin  out  NREG  one-hot register-in select
- opcode  out  5  ALU operation code

## Operation
- Instruction fields: opcode = bus[31:27], ra = bus[26:23], rb = bus[22:19], rc = bus[18:15].
- Class: 00000-01110 binary; 01111 (MUL), 10000 (DIV) two-result; 10001 (NEG), 10010 (NOT) unary; 10011-11111 illegal. Any used register index >= NREG is illegal (rc ignored for unary).
- States and asserted strobes (all others 0):
  - IDLE: none. start=1 -> T0.
  - T0: PCout, IncPC, MARin, Zin.
  - T1 (MEM_WAIT+1 cycles, wait counter): Read, MDRin every cycle; Zlo_out, PCin first cycle only.
  - T2: MDRout, IRin. Exit edge captures bus; illegal -> ERR, else by class.
  - Binary: T3 rout[rb], Yin; T4 rout[rc], opcode, Zin; T5 Zlo_out, rin[ra], done.
  - Unary: T3 rout[rb], opcode, Zin; T4 Zlo_out, rin[ra], done.
  - Two-result: T3 rout[rb], Yin; T4 rout[rc], opcode, Zin; T5 Zlo_out, LOin; T6 Zhi_out, HIin, done.
  - ERR: done, err; no register, LO or HI write.
- opcode output holds the captured opcode from T3 until the done cycle inclusive; 0 in IDLE and fetch.
- From any done cycle: start=1 -> T0 next cycle (back-to-back), else IDLE.
- start while busy (other than the done cycle) is ignored.

## Timing
- All outputs registered: strobes for a state are visible in the cycle after the edge that enters it.
- Reset: state IDLE, wait counter 0, captured instruction 0, every output 0 (rout, rin, opcode = 0). clear mid-instruction forces this immediately, no partial write afterwards.
- Latency from the start-sampling edge to the done cycle: binary 6+MEM_WAIT, unary 5+MEM_WAIT, two-result 7+MEM_WAIT, illegal 4+MEM_WAIT cycles.
- rout and rin are never both non-zero in one cycle; at most one bit of each set.

## Configuration
- ALU_SEQ_R0_GUARD_EN defined: ra = 0 is treated as illegal (ERR path, err pulse, R0 never written). Undefined: ra = 0 is a normal destination and rin[0] is driven.

## Test plan
- Reset mid-T1 with MEM_WAIT=0: clear asserted -> all outputs 0 same cycle, busy=0; after release, start -> T0 strobes (PCout, IncPC, MARin, Zin).
- Binary AND, bus=0x28918000 in T2: T3 rout=0x0004+Yin; T4 rout=0x0008, opcode=00101, Zin; T5 Zlo_out, rin=0x0002, done; 6 cycles total.
- NEG, bus=0x8B380000: T3 rout=0x0080, opcode=10001, Zin; T4 Zlo_out, rin=0x0040, done; err=0; 5 cycles total.
- MUL with MEM_WAIT=2, bus=opcode 01111 ra=0 rb=4 rc=5: Read/MDRin high 3 cycles, PCin 1 cycle; T5 Zlo_out+LOin, T6 Zhi_out+HIin+done; 9 cycles total.
- Illegal opcode 11000, and NREG=8 with rb=9: ERR state, done=err=1 one cycle, rin=0, LOin=HIin=0.
- Back-to-back: start held high through done -> T0 strobes in the following cycle, busy stays 1; with ALU_SEQ_R0_GUARD_EN, ra=0 binary -> err pulse, rin never 0x0001.
